// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the processor run controller: FSM states, host command opcodes
// and the default halt instruction (ebreak).
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_CORE_RST = 3'd2,
      ST_RUN      = 3'd3,
      ST_STEP     = 3'd4,
      ST_HALTED   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_RUN  = 2'd1,
      OP_STEP = 2'd2,
      OP_HALT = 2'd3
   } cmd_op_t;

   localparam logic [31:0] DEFAULT_HALT_INSTRUCTION = 32'h00100073;

endpackage

// File: rtl/run_ctrl_loader.sv
// Program-image loader: writes each accepted beat straight to instruction memory (zero latency).
// load_ready follows the LOAD state only; an overflowing beat ends the image and raises a sticky error.
module run_ctrl_loader
   import run_ctrl_pkg::*;
#(
   parameter int IMEM_ADDR_WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       active,
   input  logic                       load_valid,
   input  logic [31:0]                load_data,
   input  logic                       load_last,
   output logic                       load_ready,
   output logic                       load_error,
   output logic                       done,
   output logic                       imem_we,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]                imem_wdata
);

   logic [IMEM_ADDR_WIDTH-1:0] pointer;
   logic                       beat;
   logic                       at_max;

   assign load_ready = active;
   assign beat       = active && load_valid;
   assign at_max     = (pointer == {IMEM_ADDR_WIDTH{1'b1}});
   assign done       = beat && (load_last || at_max);

   assign imem_we    = beat;
   assign imem_addr  = active ? pointer : '0;
   assign imem_wdata = load_data;

   // Pointer wraps naturally at the top of memory; the wrap itself is what flags overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pointer    <= '0;
         load_error <= 1'b0;
      end else if (start) begin
         pointer    <= '0;
         load_error <= 1'b0;
      end else if (beat) begin
         pointer <= pointer + {{(IMEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
         if (at_max && !load_last) begin
            load_error <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/processor_run_controller.sv
// Run controller for the single-cycle core: image load, core reset, run/step/halt, cycle counting.
// Optional breakpoint ports under RUN_CTRL_BREAKPOINT_EN; halt gating of core_enable is combinational.
module processor_run_controller
   import run_ctrl_pkg::*;
#(
   parameter int          IMEM_ADDR_WIDTH   = 8,
   parameter int          CYCLE_COUNT_WIDTH = 32,
   parameter logic [31:0] HALT_INSTRUCTION  = DEFAULT_HALT_INSTRUCTION
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         cmd_valid,
   input  logic [1:0]                   cmd_op,
   output logic                         cmd_ready,
   output logic                         cmd_error,
   input  logic                         load_valid,
   input  logic [31:0]                  load_data,
   input  logic                         load_last,
   output logic                         load_ready,
   output logic                         load_error,
   output logic                         imem_we,
   output logic [IMEM_ADDR_WIDTH-1:0]   imem_addr,
   output logic [31:0]                  imem_wdata,
   output logic                         core_reset,
   output logic                         core_enable,
   input  logic [31:0]                  core_instruction,
`ifdef RUN_CTRL_BREAKPOINT_EN
   input  logic [31:0]                  breakpoint_pc,
   input  logic                         breakpoint_valid,
   input  logic [31:0]                  core_pc,
`endif
   input  logic [CYCLE_COUNT_WIDTH-1:0] cycle_limit,
   output logic [CYCLE_COUNT_WIDTH-1:0] cycle_count,
   output logic [2:0]                   state,
   output logic                         halted_by_instr
);

   localparam logic [CYCLE_COUNT_WIDTH-1:0] COUNT_ONE = {{(CYCLE_COUNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                       state_q, state_d;
   logic                         cmd_error_d;
   logic                         cmd_accept;
   logic                         load_start;
   logic                         load_done;
   logic                         halt_match;
   logic                         bp_hit;
   logic                         limit_hit;
   logic [CYCLE_COUNT_WIDTH-1:0] count_inc;

   assign state      = state_q;
   assign halt_match = (core_instruction == HALT_INSTRUCTION);
   assign cmd_ready  = state_q inside {ST_IDLE, ST_RUN, ST_HALTED};
   assign cmd_accept = cmd_valid && cmd_ready;
   assign core_reset = state_q inside {ST_IDLE, ST_LOAD, ST_CORE_RST};

`ifdef RUN_CTRL_BREAKPOINT_EN
   assign bp_hit = breakpoint_valid && (core_pc == breakpoint_pc);
`else
   assign bp_hit = 1'b0;
`endif

   // STEP deliberately ignores the breakpoint so a breakpointed instruction can be stepped past.
   always_comb begin
      core_enable = 1'b0;
      case (state_q)
         ST_RUN:  core_enable = !halt_match && !bp_hit;
         ST_STEP: core_enable = !halt_match;
         default: core_enable = 1'b0;
      endcase
   end

   assign count_inc = (&cycle_count) ? cycle_count : cycle_count + COUNT_ONE;
   assign limit_hit = core_enable && (cycle_limit != '0) && (count_inc == cycle_limit);

   always_comb begin
      state_d     = state_q;
      cmd_error_d = 1'b0;
      load_start  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_accept) begin
               case (cmd_op_t'(cmd_op))
                  OP_LOAD: begin
                     state_d    = ST_LOAD;
                     load_start = 1'b1;
                  end
                  OP_RUN:  state_d = ST_CORE_RST;
                  default: cmd_error_d = 1'b1;
               endcase
            end
         end
         ST_LOAD: begin
            if (load_done) state_d = ST_IDLE;
         end
         ST_CORE_RST: state_d = ST_RUN;
         ST_RUN: begin
            if (halt_match || limit_hit || bp_hit) state_d = ST_HALTED;
            if (cmd_accept) begin
               if (cmd_op_t'(cmd_op) == OP_HALT) state_d = ST_HALTED;
               else cmd_error_d = 1'b1;
            end
         end
         ST_STEP: state_d = ST_HALTED;
         ST_HALTED: begin
            if (cmd_accept) begin
               case (cmd_op_t'(cmd_op))
                  OP_LOAD: begin
                     state_d    = ST_LOAD;
                     load_start = 1'b1;
                  end
                  OP_RUN:  state_d = ST_RUN;
                  OP_STEP: state_d = ST_STEP;
                  default: cmd_error_d = 1'b1;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         cmd_error       <= 1'b0;
         cycle_count     <= '0;
         halted_by_instr <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_error <= cmd_error_d;
         if (state_q == ST_CORE_RST) begin
            cycle_count     <= '0;
            halted_by_instr <= 1'b0;
         end else begin
            if (core_enable) cycle_count <= count_inc;
            if ((state_q == ST_RUN || state_q == ST_STEP) && halt_match) halted_by_instr <= 1'b1;
         end
      end
   end

   run_ctrl_loader #(
      .IMEM_ADDR_WIDTH (IMEM_ADDR_WIDTH)
   ) u_loader (
      .clock      (clock),
      .reset      (reset),
      .start      (load_start),
      .active     (state_q == ST_LOAD),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .load_error (load_error),
      .done       (load_done),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata)
   );

endmodule

// File: tb/tb_processor_run_controller.sv
// Directed bench: a 4-word instruction memory and a trivial PC model stand in for the core.
module tb_processor_run_controller;

   localparam int AW = 2;
   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_op = 2'd0;
   logic          cmd_ready, cmd_error;
   logic          load_valid = 1'b0;
   logic [31:0]   load_data = 32'd0;
   logic          load_last = 1'b0;
   logic          load_ready, load_error;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_reset, core_enable;
   logic [31:0]   core_instruction;
   logic [CW-1:0] cycle_limit = '0;
   logic [CW-1:0] cycle_count;
   logic [2:0]    state;
   logic          halted_by_instr;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [4];
   logic [AW-1:0] pc;
   logic [31:0] prog_halt [4] = '{32'h00500093, 32'h00308113, 32'h002081b3, 32'h00100073};
   logic [31:0] prog_free [4] = '{32'h00000013, 32'h00108093, 32'h00210113, 32'h00318193};

   always #5 clock = ~clock;

   processor_run_controller #(
      .IMEM_ADDR_WIDTH   (AW),
      .CYCLE_COUNT_WIDTH (CW)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_op           (cmd_op),
      .cmd_ready        (cmd_ready),
      .cmd_error        (cmd_error),
      .load_valid       (load_valid),
      .load_data        (load_data),
      .load_last        (load_last),
      .load_ready       (load_ready),
      .load_error       (load_error),
      .imem_we          (imem_we),
      .imem_addr        (imem_addr),
      .imem_wdata       (imem_wdata),
      .core_reset       (core_reset),
      .core_enable      (core_enable),
      .core_instruction (core_instruction),
      .cycle_limit      (cycle_limit),
      .cycle_count      (cycle_count),
      .state            (state),
      .halted_by_instr  (halted_by_instr)
   );

   always @(posedge clock) begin
      if (imem_we) mem[imem_addr] <= imem_wdata;
      if (core_reset) pc <= '0;
      else if (core_enable) pc <= pc + 2'd1;
   end
   assign core_instruction = mem[pc];

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [1:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic load_image(input int sel);
      issue(2'd0);
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = (sel == 0) ? prog_halt[i] : prog_free[i];
         load_last  = (i == 3);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
      n_cmp++; if (core_reset !== 1'b1 || core_enable !== 1'b0) begin n_bad++; $display("FAIL rst_core: rst=%b en=%b want 1/0", core_reset, core_enable); end
      n_cmp++; if (imem_we !== 1'b0 || imem_addr !== '0) begin n_bad++; $display("FAIL rst_imem: we=%b addr=%0d want 0/0", imem_we, imem_addr); end
      n_cmp++; if (cycle_count !== '0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", cycle_count); end
      n_cmp++; if ({cmd_error, load_error, halted_by_instr} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {cmd_error, load_error, halted_by_instr}); end
      @(negedge clock);
      reset = 1'b1;
      tick();
      n_cmp++; if (cmd_ready !== 1'b1 || state !== 3'd0) begin n_bad++; $display("FAIL rst_release: ready=%b state=%0d want 1/0", cmd_ready, state); end
   endtask

   task automatic test_load;
      issue(2'd0);
      n_cmp++; if (state !== 3'd1 || load_ready !== 1'b1 || cmd_ready !== 1'b0) begin n_bad++; $display("FAIL load_enter: state=%0d lrdy=%b crdy=%b want 1/1/0", state, load_ready, cmd_ready); end
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = prog_halt[i];
         load_last  = (i == 3);
         #1;
         n_cmp++; if (imem_we !== 1'b1 || imem_addr !== AW'(i) || imem_wdata !== prog_halt[i]) begin n_bad++; $display("FAIL load_beat%0d: we=%b addr=%0d data=%h want 1/%0d/%h", i, imem_we, imem_addr, imem_wdata, i, prog_halt[i]); end
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      #1;
      n_cmp++; if (state !== 3'd0 || load_error !== 1'b0 || load_ready !== 1'b0) begin n_bad++; $display("FAIL load_done: state=%0d err=%b rdy=%b want 0/0/0", state, load_error, load_ready); end
      n_cmp++; if (mem[0] !== prog_halt[0] || mem[3] !== prog_halt[3]) begin n_bad++; $display("FAIL load_mem: m0=%h m3=%h want %h/%h", mem[0], mem[3], prog_halt[0], prog_halt[3]); end
   endtask

   task automatic test_run;
      issue(2'd1);
      n_cmp++; if (state !== 3'd2 || core_reset !== 1'b1 || core_enable !== 1'b0) begin n_bad++; $display("FAIL run_corerst: state=%0d rst=%b en=%b want 2/1/0", state, core_reset, core_enable); end
      tick();
      n_cmp++; if (state !== 3'd3 || core_reset !== 1'b0 || core_enable !== 1'b1) begin n_bad++; $display("FAIL run_enter: state=%0d rst=%b en=%b want 3/0/1", state, core_reset, core_enable); end
      repeat (3) tick();
      n_cmp++; if (core_enable !== 1'b0 || state !== 3'd3 || cycle_count !== 8'd3) begin n_bad++; $display("FAIL run_haltword: en=%b state=%0d cnt=%0d want 0/3/3", core_enable, state, cycle_count); end
      tick();
      n_cmp++; if (state !== 3'd5 || halted_by_instr !== 1'b1 || cycle_count !== 8'd3) begin n_bad++; $display("FAIL run_halted: state=%0d hbi=%b cnt=%0d want 5/1/3", state, halted_by_instr, cycle_count); end
   endtask

   task automatic test_limit;
      cycle_limit = 8'd2;
      load_image(1);
      issue(2'd1);
      repeat (2) tick();
      n_cmp++; if (state !== 3'd3 || cycle_count !== 8'd1) begin n_bad++; $display("FAIL limit_early: state=%0d cnt=%0d want 3/1", state, cycle_count); end
      tick();
      n_cmp++; if (state !== 3'd5 || cycle_count !== 8'd2 || halted_by_instr !== 1'b0) begin n_bad++; $display("FAIL limit_hit: state=%0d cnt=%0d hbi=%b want 5/2/0", state, cycle_count, halted_by_instr); end
   endtask

   task automatic test_step;
      cycle_limit = '0;
      issue(2'd2);
      n_cmp++; if (state !== 3'd4 || cmd_ready !== 1'b0 || core_enable !== 1'b1) begin n_bad++; $display("FAIL step_enter: state=%0d rdy=%b en=%b want 4/0/1", state, cmd_ready, core_enable); end
      tick();
      n_cmp++; if (state !== 3'd5 || cycle_count !== 8'd3 || core_enable !== 1'b0) begin n_bad++; $display("FAIL step1: state=%0d cnt=%0d en=%b want 5/3/0", state, cycle_count, core_enable); end
      issue(2'd2);
      tick();
      n_cmp++; if (state !== 3'd5 || cycle_count !== 8'd4) begin n_bad++; $display("FAIL step2: state=%0d cnt=%0d want 5/4", state, cycle_count); end
      load_image(1);
      issue(2'd2);
      n_cmp++; if (cmd_error !== 1'b1 || state !== 3'd0) begin n_bad++; $display("FAIL step_idle_err: err=%b state=%0d want 1/0", cmd_error, state); end
      tick();
      n_cmp++; if (cmd_error !== 1'b0 || state !== 3'd0) begin n_bad++; $display("FAIL step_idle_pulse: err=%b state=%0d want 0/0", cmd_error, state); end
   endtask

   task automatic test_overflow;
      issue(2'd0);
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = 32'hA0 + 32'(i);
         load_last  = 1'b0;
         tick();
      end
      n_cmp++; if (state !== 3'd0 || load_error !== 1'b1 || load_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_flag: state=%0d err=%b rdy=%b want 0/1/0", state, load_error, load_ready); end
      load_data = 32'hA4;
      #1;
      n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL ovf_word5_we: got %b want 0", imem_we); end
      tick();
      load_valid = 1'b0;
      n_cmp++; if (mem[0] !== 32'hA0 || mem[3] !== 32'hA3) begin n_bad++; $display("FAIL ovf_mem: m0=%h m3=%h want a0/a3", mem[0], mem[3]); end
      issue(2'd0);
      n_cmp++; if (load_error !== 1'b0 || state !== 3'd1) begin n_bad++; $display("FAIL ovf_clear: err=%b state=%0d want 0/1", load_error, state); end
      load_valid = 1'b1;
      load_data  = 32'h00000013;
      load_last  = 1'b1;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic test_run_errors;
      issue(2'd1);
      tick();
      issue(2'd2);
      n_cmp++; if (cmd_error !== 1'b1 || state !== 3'd3) begin n_bad++; $display("FAIL run_badop: err=%b state=%0d want 1/3", cmd_error, state); end
      repeat (260) tick();
      n_cmp++; if (cycle_count !== 8'hFF || state !== 3'd3) begin n_bad++; $display("FAIL saturate: cnt=%0d state=%0d want 255/3", cycle_count, state); end
      issue(2'd3);
      n_cmp++; if (state !== 3'd5 || cycle_count !== 8'hFF || halted_by_instr !== 1'b0) begin n_bad++; $display("FAIL host_halt: state=%0d cnt=%0d hbi=%b want 5/255/0", state, cycle_count, halted_by_instr); end
   endtask

   task automatic test_reset_midrun;
      load_image(1);
      issue(2'd1);
      repeat (8) tick();
      n_cmp++; if (cycle_count !== 8'd7 || state !== 3'd3) begin n_bad++; $display("FAIL mid_pre: cnt=%0d state=%0d want 7/3", cycle_count, state); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (state !== 3'd0 || core_reset !== 1'b1 || core_enable !== 1'b0 || cycle_count !== '0) begin n_bad++; $display("FAIL mid_async: state=%0d rst=%b en=%b cnt=%0d want 0/1/0/0", state, core_reset, core_enable, cycle_count); end
      #1 reset = 1'b1;
      tick();
      load_image(0);
      issue(2'd1);
      repeat (5) tick();
      n_cmp++; if (state !== 3'd5 || cycle_count !== 8'd3 || halted_by_instr !== 1'b1) begin n_bad++; $display("FAIL mid_rerun: state=%0d cnt=%0d hbi=%b want 5/3/1", state, cycle_count, halted_by_instr); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_run();
      test_limit();
      test_step();
      test_overflow();
      test_run_errors();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
